aabb_closest_hit_reducer: RTL
=============================

Name: aabb_closest_hit_reducer

Overview:
- Sits directly downstream of the AABB hit stage (AABBHit / AABBAnyHit).
- Receives one HitData per primitive tested against the current ray, streamed serially with a valid/ready handshake.
- Keeps the nearest valid hit in a register and emits one resolved HitData per ray to the shading/raygen stage.
- Includes a primitive counter with overrun protection, so a missing last flag cannot hang the ray core.

Parameters:
- MAX_PRIMS, 256: maximum number of primitives per ray. The counter is $clog2(MAX_PRIMS)+1 bits wide.
- FIXED_W, `FIXED_WIDTH: width of Fixed T values. Used only for sizing; the Fixed type supplies the comparison.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- ray_start  input  1  one-cycle pulse; begins a new ray. Accepted only in IDLE.
- in_valid  input  1  in_hit/in_last are valid this cycle.
- in_ready  output  1  reducer accepts an input this cycle.
- in_hit  input  HitData  result of one AABB test (bHit, T, PI, Color, SurfaceType, Normal).
- in_last  input  1  marks the final primitive for this ray.
- out_valid  output  1  out_hit holds the resolved result for the ray.
- out_ready  input  1  consumer accepts out_hit.
- out_hit  output  HitData  nearest hit. bHit=0 and PI=`NULL_PRIMITIVE_INDEX if nothing was hit.
- out_overrun  output  1  qualified by out_valid; the ray ended by count limit, not by in_last.
- busy  output  1  high in ACCUM or DONE.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, count=0.
  - best.bHit=0, best.PI=`NULL_PRIMITIVE_INDEX, best.T=0.
  - out_valid=0, in_ready=0, out_overrun=0, busy=0.
  - Reset during ACCUM or DONE discards the ray; no output is produced for it.
- IDLE:
  - in_ready=0.
  - On ray_start: clear best to the null hit, set count=0, go to ACCUM.
- ACCUM:
  - in_ready=1. A beat is transferred when in_valid && in_ready.
  - On each beat:
    - count increments.
    - If in_hit.bHit and (!best.bHit or in_hit.T < best.T, signed Fixed compare), best<=in_hit.
    - Equal T keeps the earlier primitive (strict less-than).
    - Beats with bHit=0 never modify best.
  - On a beat with in_last=1: go to DONE, out_overrun<=0. That last beat's hit takes part in the min.
  - On a beat where count reaches MAX_PRIMS-1 with in_last=0: go to DONE, out_overrun<=1.
  - in_valid=0 stalls the reducer with no change.
  - ray_start is ignored.
- DONE:
  - out_valid=1, out_hit=best, in_ready=0.
  - Hold outputs stable until out_ready.
  - On out_valid && out_ready: go to IDLE next cycle.
  - Back-to-back rays: a ray_start asserted in the same cycle as the out_ready handshake is ignored. The upstream re-issues it once the reducer is in IDLE (minimum 1 bubble).
- Latency: out_valid rises on the cycle after the in_last beat. Throughput is one primitive per cycle.
- out_hit is a register output with no combinational path from in_hit.
- Zero-primitive ray: upstream must send at least one beat; a beat with bHit=0 and in_last=1 yields a null result.

Optional Feature:
- Macro: AABB_REDUCER_ANYHIT_EN.
- Defined (shadow/any-hit rays):
  - The first beat with bHit=1 is stored and the state moves to DRAIN.
  - DRAIN holds in_ready=1, sinks beats without updating best, and leaves on in_last or count limit into DONE.
  - out_hit is that first hit, not necessarily the nearest.
- Undefined: no DRAIN state exists and behaviour is closest-hit as above.

Decomposition:
- Shared package/Types.sv: the ReducerState enum (IDLE, ACCUM, DONE, DRAIN) and a NULL_HIT HitData constant. HitData, Fixed and `NULL_PRIMITIVE_INDEX are reused as-is.
- One sub-module, hit_nearer_select: combinational; takes (best, cand), returns the replace flag. It wraps Fixed_Less and the bHit gating.
- FSM and counter stay in the top module.

Test Plan:
1. Closest hit: ray_start, then 4 beats with T = 5.0 hit, 2.0 hit, 3.0 hit, 1.0 miss (last) -> out_hit.T=2.0, PI of beat 2, out_overrun=0, out_valid 1 cycle after the last beat.
2. All misses, plus tie: 3 miss beats -> bHit=0, PI=NULL. Separately, T=4.0 (PI=7) then T=4.0 (PI=9) -> PI=7.
3. Backpressure: hold in_valid low 3 cycles mid-ray, then hold out_ready low 5 cycles -> best unchanged during stall; out_hit stable and out_valid high until the handshake; then IDLE.
4. Overrun: MAX_PRIMS=8, 8 beats with in_last=0 -> DONE after the 8th beat, out_overrun=1, in_ready=0 thereafter.
5. Reset mid-ray: assert reset asynchronously during ACCUM after 2 hits -> outputs at reset values immediately; the next ray starts with best=null.
6. AABB_REDUCER_ANYHIT_EN: beats T=6.0 hit, 1.0 hit, last miss -> out_hit.T=6.0, all 3 beats accepted, out_valid after the last beat.

Source files
------------

// File: rtl/aabb_closest_hit_reducer_pkg.sv
// Shared types for the AABB closest-hit reducer: the hit record, the signed
// fixed-point T, the reducer state enum and the null-hit constant.
// The optional any-hit mode (macro AABB_REDUCER_ANYHIT_EN) uses the DRAIN state.
`ifndef FIXED_WIDTH
`define FIXED_WIDTH 32
`endif
`ifndef NULL_PRIMITIVE_INDEX
`define NULL_PRIMITIVE_INDEX 16'hFFFF
`endif

package aabb_closest_hit_reducer_pkg;

    localparam int FIXED_W = `FIXED_WIDTH;
    localparam int PI_W    = 16;
    localparam logic [PI_W-1:0] NULL_PI = `NULL_PRIMITIVE_INDEX;

    // Signed fixed-point distance along the ray.
    typedef logic signed [FIXED_W-1:0] Fixed;

    typedef struct packed {
        logic            bHit;
        Fixed            T;
        logic [PI_W-1:0] PI;
        logic [23:0]     Color;
        logic [3:0]      SurfaceType;
        logic [47:0]     Normal;
    } HitData;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } ReducerState;

    localparam HitData NULL_HIT = '{bHit: 1'b0, T: '0, PI: NULL_PI,
                                    Color: '0, SurfaceType: '0, Normal: '0};

    // Signed strict less-than on Fixed values.
    function automatic logic Fixed_Less(input Fixed a, input Fixed b);
        return a < b;
    endfunction

endpackage

// File: rtl/hit_nearer_select.sv
// Decides whether a candidate hit replaces the current best hit.
// A miss never replaces; any hit replaces an empty best; otherwise strictly
// smaller T wins, so equal T keeps the earlier primitive.
module hit_nearer_select
    import aabb_closest_hit_reducer_pkg::*;
(
    input  logic best_hit,
    input  Fixed best_t,
    input  logic cand_hit,
    input  Fixed cand_t,
    output logic replace
);

    assign replace = cand_hit && (!best_hit || Fixed_Less(cand_t, best_t));

endmodule

// File: rtl/aabb_closest_hit_reducer.sv
// Reduces the serial stream of per-primitive AABB results of one ray to a
// single resolved hit. A primitive counter ends the ray if in_last never
// arrives, flagged by out_overrun.
// Optional macro AABB_REDUCER_ANYHIT_EN: keep the first hit and drain the rest.
module aabb_closest_hit_reducer
    import aabb_closest_hit_reducer_pkg::*;
#(
    parameter int MAX_PRIMS = 256
)
(
    input  logic   clk,
    input  logic   reset,
    input  logic   ray_start,
    input  logic   in_valid,
    output logic   in_ready,
    input  HitData in_hit,
    input  logic   in_last,
    output logic   out_valid,
    input  logic   out_ready,
    output HitData out_hit,
    output logic   out_overrun,
    output logic   busy
);

    localparam int CW = $clog2(MAX_PRIMS) + 1;
    localparam logic [CW-1:0] LIMIT = CW'(MAX_PRIMS - 1);

    ReducerState   state, state_nxt;
    HitData        best, best_nxt;
    logic [CW-1:0] count, count_nxt;
    logic          overrun, overrun_nxt;
    logic          replace;
    logic          beat;
    logic          at_limit;

    hit_nearer_select u_sel (
        .best_hit (best.bHit),
        .best_t   (best.T),
        .cand_hit (in_hit.bHit),
        .cand_t   (in_hit.T),
        .replace  (replace)
    );

`ifdef AABB_REDUCER_ANYHIT_EN
    assign in_ready = (state == ACCUM) || (state == DRAIN);
`else
    assign in_ready = (state == ACCUM);
`endif
    assign beat        = in_valid && in_ready;
    assign at_limit    = (count == LIMIT);
    assign out_valid   = (state == DONE);
    assign out_hit     = best;
    assign out_overrun = overrun;
    assign busy        = (state != IDLE);

    // Next state and next datapath values; everything holds unless a case moves it.
    always_comb begin
        state_nxt   = state;
        best_nxt    = best;
        count_nxt   = count;
        overrun_nxt = overrun;
        case (state)
            IDLE: begin
                if (ray_start) begin
                    best_nxt    = NULL_HIT;
                    count_nxt   = '0;
                    overrun_nxt = 1'b0;
                    state_nxt   = ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    count_nxt = count + 1'b1;
                    if (replace) best_nxt = in_hit;
                    if (in_last) begin
                        state_nxt   = DONE;
                        overrun_nxt = 1'b0;
                    end else if (at_limit) begin
                        state_nxt   = DONE;
                        overrun_nxt = 1'b1;
                    end
`ifdef AABB_REDUCER_ANYHIT_EN
                    else if (replace) begin
                        state_nxt = DRAIN;
                    end
`endif
                end
            end
`ifdef AABB_REDUCER_ANYHIT_EN
            DRAIN: begin
                if (beat) begin
                    count_nxt = count + 1'b1;
                    if (in_last) begin
                        state_nxt   = DONE;
                        overrun_nxt = 1'b0;
                    end else if (at_limit) begin
                        state_nxt   = DONE;
                        overrun_nxt = 1'b1;
                    end
                end
            end
`endif
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, best hit, counter and overrun flag registers; reset drops any ray in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            best    <= NULL_HIT;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            best    <= best_nxt;
            count   <= count_nxt;
            overrun <= overrun_nxt;
        end
    end

endmodule
